gf_div: RTL and testbench

Sequential GF(2^SYMB_WIDTH) divider: computes quotient = dividend / divisor as dividend · divisor^-1. The inverse is formed by Fermat exponentiation, divisor^(2^SYMB_WIDTH − 2), using square-and-multiply on one shared `gf_mult` instance. It is the inverse operation of `gf_mult` and sits in the RS decoder datapath, for example Forney error-magnitude evaluation. A valid/ready handshake is used on both sides.

---
 rtl/gf_div.sv | 154 +++++++++++++++
 tb/tb_gf_div.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf_div.sv
// GF(2^SYMB_WIDTH) divider: quotient = dividend * divisor^(2^SYMB_WIDTH-2), built by
// square-and-multiply on a single shared field multiplier. Valid/ready on both sides.

package gf_pkg;
    localparam int unsigned SYMB_WIDTH = 8;
    // Field polynomial x^8 + x^4 + x^3 + x^2 + 1, matching the RS codec.
    localparam logic [SYMB_WIDTH:0] FIELD_POLY = 9'h11D;
endpackage

// Combinational GF(2^WIDTH) multiplier, shift-and-add with per-step reduction.
module gf_mult #(
    parameter int unsigned       WIDTH = gf_pkg::SYMB_WIDTH,
    parameter logic [WIDTH:0]    POLY  = gf_pkg::FIELD_POLY
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product_c
);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        acc     = '0;
        shifted = a;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (b[i]) begin
                acc = acc ^ shifted;
            end
            shifted = {shifted[WIDTH-2:0], 1'b0} ^ (shifted[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
        end
        product_c = acc;
    end
endmodule

module gf_div (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [gf_pkg::SYMB_WIDTH-1:0] dividend,
    input  logic [gf_pkg::SYMB_WIDTH-1:0] divisor,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [gf_pkg::SYMB_WIDTH-1:0] quotient,
    output logic                          div_by_zero
);
    localparam int unsigned W     = gf_pkg::SYMB_WIDTH;
    localparam int unsigned STEPS = 2 * W - 2;
    localparam int unsigned K_W   = $clog2(2 * W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           in_ready_next;
    logic           out_valid_next;
    logic           accept;
    logic           step;
    logic           last_step;
    logic [K_W-1:0] k;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   acc;
    logic [W-1:0]   mul_b;
    logic [W-1:0]   product;

    assign last_step = (k == K_W'(STEPS));

    // Odd steps square the accumulator; even steps multiply by B, the final one by A.
    always_comb begin
        mul_b = acc;
        if (!k[0]) begin
            mul_b = last_step ? op_a : op_b;
        end
    end

    gf_mult #(
        .WIDTH (W),
        .POLY  (gf_pkg::FIELD_POLY)
    ) u_mult (
        .a         (acc),
        .b         (mul_b),
        .product_c (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
        end
    end

    // Handshake flags are registered from the next state so they decode state only.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    // Datapath: operands captured once at accept; a zero divisor keeps acc at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            k           <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_a        <= dividend;
            op_b        <= divisor;
            acc         <= divisor;
            k           <= K_W'(1);
            div_by_zero <= (divisor == '0);
        end else if (step) begin
            acc <= product;
            k   <= k + K_W'(1);
            if (last_step) begin
                quotient <= product;
            end
        end
    end
endmodule

// File: tb/tb_gf_div.sv
// Directed and randomised checks of gf_div over GF(2^8) with polynomial 0x11D.

module tb_gf_div;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    // Full carry-less product, then reduce from the top bit down.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011D << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        for (int x = 0; x < 256; x++) begin
            if (ref_mul(8'(x), b) == a) return 8'(x);
        end
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation with out_ready held high; checks latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_q, input logic exp_z);
        int n;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = 8'h00;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd14);
        check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
        tick;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_post"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int         n;
        int         results;
        int         dups;
        logic       seen;
        logic       stable;
        logic       got;
        logic       ro;
        logic [7:0] q0;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] exp_bp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'h00;
        divisor   = 8'h00;
        tick;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick;

        run_op("identity", 8'h57, 8'h01, 8'h57, 1'b0);
        run_op("self", 8'h02, 8'h02, 8'h01, 1'b0);
        run_op("inverse", 8'h01, 8'h02, 8'h8E, 1'b0);
        run_op("zero_num", 8'h00, 8'h35, 8'h00, 1'b0);
        run_op("zero_den", 8'h35, 8'h00, 8'h00, 1'b1);
        run_op("inverse2", 8'h01, 8'h02, 8'h8E, 1'b0);

        // Abort a zero-divisor op at k = 5: old quotient 0x8E and flag 1 must both clear.
        dividend = 8'h01;
        divisor  = 8'h00;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check("abort_pre_quotient", 32'(quotient), 32'h8E);
        check("abort_pre_dbz", 32'(div_by_zero), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 8'h01, 8'h02, 8'h8E, 1'b0);

        // Reset and in_valid together: nothing may be accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        dividend = 8'h05;
        divisor  = 8'h03;
        tick;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick;
        check("rst_vs_valid_idle", 32'(in_ready), 32'd1);

        // Backpressure: result and flags hold for 20 cycles, then release.
        exp_bp    = ref_div(8'hA3, 8'h4C);
        out_ready = 1'b0;
        dividend  = 8'hA3;
        divisor   = 8'h4C;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        divisor  = 8'h11;
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check("bp_latency", 32'(n), 32'd14);
        check("bp_quotient", 32'(quotient), 32'(exp_bp));
        q0     = quotient;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (quotient !== q0 || div_by_zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        tick;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);

        // Random sweep with idle gaps and random out_ready.
        results = 0;
        dups    = 0;
        for (int op = 0; op < 400; op++) begin
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) tick;
            ra       = 8'($urandom);
            rb       = 8'($urandom_range(1, 255));
            dividend = ra;
            divisor  = rb;
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            got = 1'b0;
            n   = 0;
            while (!got && n < 100) begin
                ro        = 1'($urandom_range(0, 1));
                out_ready = ro;
                if (out_valid && ro) begin
                    got = 1'b1;
                    results++;
                    check("rand_product", {23'd0, div_by_zero, ref_mul(quotient, rb)}, {24'd0, ra});
                end
                tick;
                n++;
            end
            if (out_valid) dups++;
        end
        out_ready = 1'b0;
        check("rand_results", 32'(results), 32'd400);
        check("rand_no_dup", 32'(dups), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
